// File: rtl/fp_sqrt_pkg.sv
// rtl/fp_sqrt_pkg.sv - shared types and format helpers for the iterative square root
package fp_sqrt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_ITER,
    ST_ROUND,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    CL_ZERO,
    CL_SUB,
    CL_NORM,
    CL_INF,
    CL_QNAN,
    CL_SNAN
  } op_class_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set, rest zero.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
  endfunction

  function automatic op_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_zero, input logic frac_msb);
    if (exp_ones) begin
      if (frac_zero) return CL_INF;
      return frac_msb ? CL_QNAN : CL_SNAN;
    end
    if (exp_zero) return frac_zero ? CL_ZERO : CL_SUB;
    return CL_NORM;
  endfunction

endpackage

// File: rtl/fp_sqrt_step.sv
// rtl/fp_sqrt_step.sv - one radix-2 restoring square-root recurrence step
//
// Purpose: shift two radicand bits into the partial remainder, compare with the
// trial value {root,01}, subtract on success and append the new root bit.
// Ports:
//   rem_i  / rem_o   partial remainder in / out (R+2 bits)
//   root_i / root_o  partial root in / out (R bits, grows from the LSB)
//   bits_i           next two radicand bits, MSB first
module fp_sqrt_step #(
  parameter int R = 25
) (
  input  logic [R+1:0] rem_i,
  input  logic [R-1:0] root_i,
  input  logic [1:0]   bits_i,
  output logic [R+1:0] rem_o,
  output logic [R-1:0] root_o
);

  logic [R+3:0] rem_sh;
  logic [R+1:0] trial;
  logic         ge;

  assign rem_sh = {rem_i, bits_i};
  assign trial  = {root_i, 2'b01};
  assign ge     = rem_sh >= {2'b00, trial};
  // The true remainder always fits in R+2 bits, so modular subtraction is exact.
  assign rem_o  = rem_sh[R+1:0] - (ge ? trial : '0);
  assign root_o = {root_i[R-2:0], ge};

endmodule

// File: rtl/fp_sqrt_iter.sv
// rtl/fp_sqrt_iter.sv - multi-cycle digit-recurrence IEEE-754 square root
//
// Purpose: one operation in flight; operand accepted in IDLE, classified and
// normalised in NORM, BPC root bits per ITER cycle, RNE rounding in ROUND,
// result held in DONE until consumed.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (in_ready high only in IDLE)
//   in_a                 operand {sign,exp,frac}
//   out_valid/out_ready  result handshake (result held while stalled)
//   out_y                square root, round-to-nearest-even
//   out_nv, out_nx       invalid and inexact flags
module fp_sqrt_iter
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BPC   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_y,
  output logic                   out_nv,
  output logic                   out_nx
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int N_ITER = (MAN_W + 2 + BPC - 1) / BPC;
  localparam int R      = N_ITER * BPC;
  localparam int CW     = $clog2(N_ITER + 1);
  localparam int BIAS   = fp_bias(EXP_W);
  localparam logic [W-1:0]  QNAN     = W'(canon_nan(EXP_W, MAN_W));
  // Root bits that lie below the guard bit feed the sticky bit.
  localparam logic [R-1:0]  LOW_MASK = {R{1'b1}} >> (MAN_W + 2);
  localparam logic [CW-1:0] LAST     = CW'(N_ITER - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [2*R-1:0]     x_q, x_d;
  logic [R+1:0]       rem_q, rem_d;
  logic [R-1:0]       root_q, root_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [W-1:0]       y_q, y_d;
  logic               nv_q, nv_d, nx_q, nx_d;

  // Operand decode and normalisation (used in NORM).
  logic               sgn;
  logic [EXP_W-1:0]   expf;
  logic [MAN_W-1:0]   frac;
  op_class_e          cls;
  int                 lz, e_un, e_ev;
  logic [MAN_W:0]     mant;
  logic [MAN_W+1:0]   rad;
  logic [EXP_W-1:0]   res_exp;

  assign sgn  = a_q[W-1];
  assign expf = a_q[W-2:MAN_W];
  assign frac = a_q[MAN_W-1:0];
  assign cls  = classify(expf == '0, &expf, frac == '0, frac[MAN_W-1]);

  always_comb begin
    lz = MAN_W;
    for (int i = 0; i < MAN_W; i++) begin
      if (frac[i]) lz = MAN_W - 1 - i;
    end
  end

  always_comb begin
    mant    = '0;
    e_un    = 0;
    e_ev    = 0;
    rad     = '0;
    res_exp = '0;
    if (cls == CL_SUB) begin
      mant = {1'b0, frac} << (lz + 1);
      e_un = 1 - BIAS - (lz + 1);
    end else begin
      mant = {1'b1, frac};
      e_un = int'(expf) - BIAS;
    end
    // An odd exponent is made even by doubling the radicand.
    e_ev    = e_un[0] ? e_un - 1 : e_un;
    rad     = e_un[0] ? {mant, 1'b0} : {1'b0, mant};
    res_exp = EXP_W'((e_ev >>> 1) + BIAS);
  end

  // Recurrence chain: BPC steps per cycle, consuming radicand MSBs first.
  logic [R+1:0] rem_c  [0:BPC];
  logic [R-1:0] root_c [0:BPC];

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  for (genvar j = 0; j < BPC; j++) begin : g_step
    fp_sqrt_step #(.R(R)) u_step (
      .rem_i  (rem_c[j]),
      .root_i (root_c[j]),
      .bits_i (x_q[2*R-1-2*j -: 2]),
      .rem_o  (rem_c[j+1]),
      .root_o (root_c[j+1])
    );
  end

  // Rounding: root MSB is the hidden bit, a carry out renormalises.
  logic [MAN_W:0]   sig_r;
  logic             guard, sticky;
  logic [MAN_W+1:0] sig_up;
  logic [MAN_W-1:0] frac_o;
  logic [EXP_W-1:0] exp_o;

  assign sig_r  = root_q[R-1 -: MAN_W+1];
  assign guard  = root_q[R-2-MAN_W];
  assign sticky = (|(root_q & LOW_MASK)) | (|rem_q);
  assign sig_up = {1'b0, sig_r} + {{(MAN_W+1){1'b0}}, guard};
  assign frac_o = sig_up[MAN_W+1] ? sig_up[MAN_W:1] : sig_up[MAN_W-1:0];
  assign exp_o  = exp_q + {{(EXP_W-1){1'b0}}, sig_up[MAN_W+1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    x_d     = x_q;
    rem_d   = rem_q;
    root_d  = root_q;
    exp_d   = exp_q;
    y_d     = y_q;
    nv_d    = nv_q;
    nx_d    = nx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        nv_d    = 1'b0;
        nx_d    = 1'b0;
        state_d = ST_DONE;
        if (cls == CL_QNAN || cls == CL_SNAN) begin
          y_d  = QNAN;
          nv_d = (cls == CL_SNAN);
        end else if (cls == CL_ZERO) begin
          y_d = a_q;
        end else if (sgn) begin
          y_d  = QNAN;
          nv_d = 1'b1;
        end else if (cls == CL_INF) begin
          y_d = a_q;
        end else begin
          x_d     = {rad, {(2*R-MAN_W-2){1'b0}}};
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          exp_d   = res_exp;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        rem_d  = rem_c[BPC];
        root_d = root_c[BPC];
        x_d    = x_q << (2 * BPC);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        y_d     = {1'b0, exp_o, frac_o};
        nv_d    = 1'b0;
        nx_d    = guard | sticky;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      x_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      exp_q   <= '0;
      y_q     <= '0;
      nv_q    <= 1'b0;
      nx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      exp_q   <= exp_d;
      y_q     <= y_d;
      nv_q    <= nv_d;
      nx_q    <= nx_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_y     = y_q;
  assign out_nv    = nv_q;
  assign out_nx    = nx_q;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb/tb_fp_sqrt_iter.sv - self-checking bench for fp_sqrt_iter (fp32, BPC=1 and BPC=2)
module tb_fp_sqrt_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a;
  logic        out_ready;
  logic        in_ready1, out_valid1, nv1, nx1;
  logic        in_ready2, out_valid2, nv2, nx2;
  logic [31:0] out_y1, out_y2;

  int checks = 0;
  int errors = 0;

  fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .BPC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a),
    .out_valid(out_valid1), .out_ready(out_ready), .out_y(out_y1), .out_nv(nv1), .out_nx(nx1)
  );

  fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .BPC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a),
    .out_valid(out_valid2), .out_ready(out_ready), .out_y(out_y2), .out_nv(nv2), .out_nx(nx2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer square root of the scaled significand, then RNE to 24 bits.
  function automatic void model(input logic [31:0] a, output logic [31:0] y,
                                output logic nv, output logic nx, output bit spc);
    longint m, e, s, mm, lo, hi, mid, r, q, ee;
    int nb, ex, fr;
    bit g, st, up;
    ex = int'(a[30:23]);
    fr = int'(a[22:0]);
    y = '0; nv = 1'b0; nx = 1'b0; spc = 1'b1;
    if (ex == 255 && fr != 0) begin
      y = 32'h7FC00000; nv = ~a[22];
    end else if (ex == 0 && fr == 0) begin
      y = a;
    end else if (a[31]) begin
      y = 32'h7FC00000; nv = 1'b1;
    end else if (ex == 255) begin
      y = a;
    end else begin
      spc = 1'b0;
      if (ex == 0) begin m = longint'(fr); e = -149; end
      else begin m = longint'(fr) + (64'sd1 << 23); e = longint'(ex) - 150; end
      if (e[0]) begin m = m << 1; e = e - 1; end
      nb = 0;
      while ((m >> nb) != 0) nb++;
      s = 61 - longint'(nb);
      if (s[0]) s = s + 1;
      mm = m << s;
      lo = 0; hi = 64'sd1 << 31;
      while (hi - lo > 1) begin
        mid = (lo + hi) >>> 1;
        if (mid * mid <= mm) lo = mid; else hi = mid;
      end
      r  = lo;
      q  = r >>> 7;
      g  = r[6];
      st = ((r & 63) != 0) || (r * r != mm);
      up = g && (st || q[0]);
      q  = q + longint'(up);
      ee = ((e - s) >>> 1) + 157;
      if (q == (64'sd1 << 24)) begin q = q >>> 1; ee = ee + 1; end
      y  = {1'b0, ee[7:0], q[22:0]};
      nx = g | st;
    end
  endfunction

  // Called just after the accepting edge; gathers both results and their latencies.
  task automatic collect(input logic [31:0] ey, input logic env, input logic enx,
                         input bit spc, input int stall, input string tag);
    int cyc, lat1, lat2;
    bit g1, g2;
    logic [31:0] y1, y2;
    logic v1, v2, x1, x2;
    cyc = 0; lat1 = -1; lat2 = -1; g1 = 0; g2 = 0;
    y1 = 'x; y2 = 'x; v1 = 'x; v2 = 'x; x1 = 'x; x2 = 'x;
    while (cyc < 200 && !(g1 && g2 && !out_valid1 && !out_valid2)) begin
      @(posedge clk); #1;
      cyc++;
      if (!g1 && out_valid1) begin g1 = 1; lat1 = cyc; y1 = out_y1; v1 = nv1; x1 = nx1; end
      if (!g2 && out_valid2) begin g2 = 1; lat2 = cyc; y2 = out_y2; v2 = nv2; x2 = nx2; end
      if (cyc >= stall) out_ready = 1'b1;
    end
    chk({tag, " y bpc1"}, y1, ey);
    chk({tag, " nv bpc1"}, 32'(v1), 32'(env));
    chk({tag, " nx bpc1"}, 32'(x1), 32'(enx));
    chk({tag, " lat bpc1"}, lat1, spc ? 1 : 27);
    chk({tag, " y bpc2"}, y2, ey);
    chk({tag, " nv bpc2"}, 32'(v2), 32'(env));
    chk({tag, " nx bpc2"}, 32'(x2), 32'(enx));
    chk({tag, " lat bpc2"}, lat2, spc ? 1 : 15);
  endtask

  task automatic launch(input logic [31:0] a, input int stall);
    @(negedge clk);
    in_a = a; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic dir_op(input logic [31:0] a, input logic [31:0] ey, input logic env,
                        input logic enx, input bit spc, input string tag);
    launch(a, 0);
    collect(ey, env, enx, spc, 0, tag);
  endtask

  task automatic rnd_op(input logic [31:0] a, input int stall);
    logic [31:0] ey; logic env, enx; bit spc;
    model(a, ey, env, enx, spc);
    launch(a, stall);
    collect(ey, env, enx, spc, stall, $sformatf("rnd %h", a));
  endtask

  initial begin
    logic [31:0] a, cap;
    int cyc, k, stall;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready1), 1);
    chk("reset out_valid", 32'(out_valid1), 0);
    chk("reset out_y", out_y1, 0);
    chk("reset nv/nx", {30'd0, nv1, nx1}, 0);
    chk("reset in_ready bpc2", 32'(in_ready2), 1);
    rst_n = 1'b1;

    dir_op(32'h40800000, 32'h40000000, 1'b0, 1'b0, 1'b0, "sqrt4");
    dir_op(32'h41100000, 32'h40400000, 1'b0, 1'b0, 1'b0, "sqrt9");
    dir_op(32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 1'b0, "sqrt2");
    dir_op(32'h00000001, 32'h1A3504F3, 1'b0, 1'b1, 1'b0, "minsub");
    dir_op(32'h00400000, 32'h1FB504F3, 1'b0, 1'b1, 1'b0, "sub2m127");
    dir_op(32'hBF800000, 32'h7FC00000, 1'b1, 1'b0, 1'b1, "neg1");
    dir_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, "negzero");
    dir_op(32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 1'b1, "posinf");
    dir_op(32'h7F800001, 32'h7FC00000, 1'b1, 1'b0, 1'b1, "snan");
    dir_op(32'h7FC00001, 32'h7FC00000, 1'b0, 1'b0, 1'b1, "qnan");
    dir_op(32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, 1'b1, "neginf");

    // Backpressure: result held, second operand held on in_valid but not taken.
    @(negedge clk);
    in_a = 32'h40000000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 32'h40800000;
    cyc = 0;
    while (!out_valid1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("bp latency", cyc, 27);
    cap = out_y1;
    chk("bp first y", cap, 32'h3FB504F3);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp hold y", out_y1, 32'h3FB504F3);
      chk("bp hold nx", 32'(nx1), 1);
      chk("bp hold valid", 32'(out_valid1), 1);
      chk("bp in_ready low", 32'(in_ready1), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp after hs valid", 32'(out_valid1), 0);
    chk("bp after hs in_ready", 32'(in_ready1), 1);
    @(posedge clk); #1;
    chk("bp next accepted", 32'(in_ready1), 0);
    in_valid = 1'b0;
    collect(32'h40000000, 1'b0, 1'b0, 1'b0, 0, "bp second");

    // Asynchronous reset in the middle of ITER.
    launch(32'h40800000, 0);
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("midreset out_valid", 32'(out_valid1), 0);
    chk("midreset in_ready", 32'(in_ready1), 1);
    chk("midreset out_valid bpc2", 32'(out_valid2), 0);
    chk("midreset in_ready bpc2", 32'(in_ready2), 1);
    @(negedge clk); rst_n = 1'b1;
    dir_op(32'h40800000, 32'h40000000, 1'b0, 1'b0, 1'b0, "after reset");

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 7);
      a = $urandom;
      case (k)
        0, 1, 2: a[31] = 1'b0;
        3: begin a[31] = 1'b0; a[30:23] = 8'h00; end
        4: a[30:23] = 8'hFF;
        6: a[31] = 1'b1;
        7: begin a[31] = 1'b0; a[30:23] = ($urandom_range(0, 1) == 1) ? 8'd254 : 8'd1; end
        default: ;
      endcase
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      rnd_op(a, stall);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
